main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter SHALL be: MEM_TIMEOUT, default 15, maximum wait cycles on mem_ready before trapping (MEM_WAIT_EN builds only).
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- OPCode  in  7  instruction opcode
- Funct  in  3  funct3
- bit30  in  1  instr[30]
- ALUFlag  in  4  {N,Z,C,V}, combinational from ALU
- mem_ready  in  1  memory access complete
- ALUControl  out  3  ALU operation
- AdrSrc, IRWrite, NextPC, MemW, RegW, PCNextSrc, ShiftSrc, RegWSrc  out  1 each  datapath controls
- ResultSrc, AluSrcA, AluSrcB, MaskEn  out  2 each  datapath mux selects
- mem_read_state  out  1  memory data phase
- trap  out  1  illegal instruction or memory timeout

Function
REQ-004 The FSM SHALL use these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, JALR_LINK, LUI, TRAP.
REQ-005 Outputs not listed for a state SHALL be 0, with ALUControl=ADD(000).
REQ-006 ALUControl encoding SHALL be: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.
REQ-007 FETCH SHALL drive AdrSrc=0, AluSrcA=01, AluSrcB=10, ResultSrc=10, PCNextSrc=1, IRWrite=1, NextPC=1, and SHALL go to DECODE.
REQ-008 DECODE SHALL drive AluSrcA=10, AluSrcB=01 (ALUOut=OLDPC+imm).
REQ-009 DECODE next-state by opcode SHALL be: 0000011/0100011→MEMADR, 0110011→EXEC_R, 0010011→EXEC_I, 1100011→BRANCH, 1101111→JAL, 1100111→JALR, 0110111→LUI, 0010111 (AUIPC)→ALUWB, any other→TRAP.
REQ-010 MEMADR SHALL drive AluSrcB=01 and SHALL go to MEMREAD for loads and MEMWRITE for stores.
REQ-011 MEMREAD SHALL drive AdrSrc=1, mem_read_state=1, and MaskEn=00/01/10 for funct3 byte/half/word, then go to MEMWB.
REQ-012 MEMWB SHALL drive ResultSrc=01, RegW=1, mem_read_state=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive AdrSrc=1, MemW=1, then go to FETCH.
REQ-014 EXEC_R SHALL decode ALUControl from Funct and bit30 (SUB only when bit30=1 and Funct=000); EXEC_I SHALL use AluSrcB=01, except slli/srli which SHALL use AluSrcB=00 and ShiftSrc=1; both SHALL go to ALUWB.
REQ-015 sra/srai/sltu/sltiu SHALL go to TRAP.
REQ-016 ALUWB SHALL drive ResultSrc=00, RegW=1, then go to FETCH.
REQ-017 BRANCH SHALL drive ALUControl=SUB and evaluate, using Z=ALUFlag[2] and N^V: beq Z, bne !Z, blt N^V, bge !(N^V); the unsupported funct3 values 010 and 011 SHALL go to TRAP.
REQ-018 When the branch is taken, BRANCH SHALL drive ResultSrc=00, PCNextSrc=1, NextPC=1; it SHALL then go to FETCH.
REQ-019 JAL SHALL drive ResultSrc=00, PCNextSrc=1, NextPC=1 (PC←target) and AluSrcA=10, AluSrcB=10 (ALUOut←OLDPC+4), then go to ALUWB.
REQ-020 JALR SHALL drive AluSrcB=01, ResultSrc=10, PCNextSrc=1, NextPC=1, then go to JALR_LINK.
REQ-021 JALR_LINK SHALL drive AluSrcA=10, AluSrcB=10, then go to ALUWB.
REQ-022 LUI SHALL drive RegWSrc=1, RegW=1, then go to FETCH.
REQ-023 TRAP SHALL drive trap=1 with all other outputs 0, and SHALL be left only by reset.

Reset
REQ-024 While rst=1, the state SHALL be FETCH, every output SHALL be forced to 0, and the timeout counter SHALL be cleared.
REQ-025 The first FETCH outputs SHALL appear in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-instruction SHALL abort the instruction, with no RegW or MemW pulse after the assertion edge.

Configuration
REQ-027 With MEM_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold state while mem_ready=0.
REQ-028 With MEM_WAIT_EN defined, IRWrite/NextPC in FETCH and MemW in MEMWRITE SHALL be asserted only in the cycle where mem_ready=1.
REQ-029 With MEM_WAIT_EN defined, a 4-bit counter SHALL count wait cycles and SHALL enter TRAP after MEM_TIMEOUT consecutive wait cycles; the counter SHALL clear on each state change.
REQ-030 Without MEM_WAIT_EN, mem_ready SHALL be ignored, each memory state SHALL last exactly one cycle, and no counter SHALL be built.

Verification
REQ-031 The bench SHALL cover add (0110011, Funct 000, bit30 0): FETCH→DECODE→EXEC_R→ALUWB→FETCH in 4 cycles, with a single RegW pulse in ALUWB.
REQ-032 The bench SHALL cover lw (Funct 010): 5 states, MaskEn=10 in MEMREAD, ResultSrc=01 with RegW=1 in MEMWB.
REQ-033 The bench SHALL cover beq with ALUFlag=0100 (taken: NextPC=1 in BRANCH) and with ALUFlag=0000 (not taken: NextPC=0); both SHALL return to FETCH.
REQ-034 The bench SHALL cover opcode 1111111: DECODE→TRAP, trap=1 held until rst, then FETCH resumes.
REQ-035 The bench SHALL cover MEM_WAIT_EN with mem_ready low 3 cycles in FETCH: IRWrite pulses once on the 4th cycle; with mem_ready held low, trap=1 after 15 wait cycles.
REQ-036 The bench SHALL cover rst asserted during MEMWRITE: MemW=0 immediately, and FETCH follows deassertion.

Source files
------------

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control FSM.
// Sequences FETCH/DECODE and the per-class execute states, driving the
// datapath enables and mux selects from the current state. Unsupported
// encodings and memory timeouts park the FSM in TRAP until reset.
// Build option: define MEM_WAIT_EN to make FETCH/MEMREAD/MEMWRITE wait on
// mem_ready, with a wait counter that traps after MEM_TIMEOUT wait cycles.
// Without it, mem_ready is ignored and every memory state lasts one cycle.
module main_control_fsm #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] OPCode,
   input  logic [2:0] Funct,
   input  logic       bit30,
   input  logic [3:0] ALUFlag,
   input  logic       mem_ready,
   output logic [2:0] ALUControl,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       MemW,
   output logic       RegW,
   output logic       PCNextSrc,
   output logic       ShiftSrc,
   output logic       RegWSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [1:0] MaskEn,
   output logic       mem_read_state,
   output logic       trap
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I,
      ALUWB, BRANCH, JAL, JALR, JALR_LINK, LUI, TRAP
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t state_reg, state_next;
   logic   mem_go;        // memory handshake done for this cycle
   logic   branch_taken;
   logic   flag_z;
   logic   flag_lt;       // signed less-than after SUB: N ^ V
   logic   unused_inputs; // carry flag is not needed by any supported branch

   assign flag_z  = ALUFlag[2];
   assign flag_lt = ALUFlag[3] ^ ALUFlag[0];

`ifdef MEM_WAIT_EN
   logic [3:0] wait_cnt_reg, wait_cnt_next;
   logic       wait_timeout;

   assign mem_go        = mem_ready;
   assign wait_timeout  = (wait_cnt_reg == 4'(MEM_TIMEOUT - 1));
   assign unused_inputs = ALUFlag[1];

   // Consecutive wait-cycle counter; cleared whenever the state changes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_cnt_reg <= '0;
      else     wait_cnt_reg <= wait_cnt_next;
   end
`else
   localparam int unsigned unused_timeout = MEM_TIMEOUT;

   assign mem_go        = 1'b1;
   assign unused_inputs = ^{ALUFlag[1], mem_ready};
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= FETCH;
      else     state_reg <= state_next;
   end

   // Next-state and output decode; everything is forced low while rst is high
   always_comb begin
      state_next     = state_reg;
      branch_taken   = 1'b0;
      ALUControl     = ALU_ADD;
      AdrSrc         = 1'b0;
      IRWrite        = 1'b0;
      NextPC         = 1'b0;
      MemW           = 1'b0;
      RegW           = 1'b0;
      PCNextSrc      = 1'b0;
      ShiftSrc       = 1'b0;
      RegWSrc        = 1'b0;
      ResultSrc      = 2'b00;
      AluSrcA        = 2'b00;
      AluSrcB        = 2'b00;
      MaskEn         = 2'b00;
      mem_read_state = 1'b0;
      trap           = 1'b0;
`ifdef MEM_WAIT_EN
      wait_cnt_next  = '0;
`endif
      if (!rst) begin
         case (state_reg)
            FETCH: begin
               // PC+4 goes straight to the PC; IR latches only on a completed read
               AluSrcA   = 2'b01;
               AluSrcB   = 2'b10;
               ResultSrc = 2'b10;
               PCNextSrc = 1'b1;
               if (mem_go) begin
                  IRWrite    = 1'b1;
                  NextPC     = 1'b1;
                  state_next = DECODE;
               end
            end
            DECODE: begin
               // Precompute OLDPC+imm for branches and AUIPC
               AluSrcA = 2'b10;
               AluSrcB = 2'b01;
               case (OPCode)
                  OP_LOAD, OP_STORE: state_next = MEMADR;
                  OP_R:              state_next = EXEC_R;
                  OP_I:              state_next = EXEC_I;
                  OP_BRANCH:         state_next = BRANCH;
                  OP_JAL:            state_next = JAL;
                  OP_JALR:           state_next = JALR;
                  OP_LUI:            state_next = LUI;
                  OP_AUIPC:          state_next = ALUWB;
                  default:           state_next = TRAP;
               endcase
            end
            MEMADR: begin
               AluSrcB    = 2'b01;
               state_next = (OPCode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
               AdrSrc         = 1'b1;
               mem_read_state = 1'b1;
               case (Funct[1:0])
                  2'b00:   MaskEn = 2'b00;
                  2'b01:   MaskEn = 2'b01;
                  default: MaskEn = 2'b10;
               endcase
               if (mem_go) state_next = MEMWB;
            end
            MEMWB: begin
               ResultSrc      = 2'b01;
               RegW           = 1'b1;
               mem_read_state = 1'b1;
               state_next     = FETCH;
            end
            MEMWRITE: begin
               AdrSrc = 1'b1;
               if (mem_go) begin
                  MemW       = 1'b1;
                  state_next = FETCH;
               end
            end
            EXEC_R: begin
               // sra and sltu encodings go to TRAP
               state_next = ALUWB;
               case (Funct)
                  3'b000: ALUControl = bit30 ? ALU_SUB : ALU_ADD;
                  3'b001: ALUControl = ALU_SLL;
                  3'b010: ALUControl = ALU_SLT;
                  3'b011: state_next = TRAP;
                  3'b100: ALUControl = ALU_XOR;
                  3'b101: begin
                     if (bit30) state_next = TRAP;
                     else       ALUControl = ALU_SRL;
                  end
                  3'b110: ALUControl = ALU_OR;
                  default: ALUControl = ALU_AND;
               endcase
            end
            EXEC_I: begin
               // Immediate shifts take shamt through the shift path, not AluSrcB
               state_next = ALUWB;
               AluSrcB    = 2'b01;
               case (Funct)
                  3'b000: ALUControl = ALU_ADD;
                  3'b001: begin
                     ALUControl = ALU_SLL;
                     AluSrcB    = 2'b00;
                     ShiftSrc   = 1'b1;
                  end
                  3'b010: ALUControl = ALU_SLT;
                  3'b011: state_next = TRAP;
                  3'b100: ALUControl = ALU_XOR;
                  3'b101: begin
                     if (bit30) begin
                        state_next = TRAP;
                     end else begin
                        ALUControl = ALU_SRL;
                        AluSrcB    = 2'b00;
                        ShiftSrc   = 1'b1;
                     end
                  end
                  3'b110: ALUControl = ALU_OR;
                  default: ALUControl = ALU_AND;
               endcase
            end
            ALUWB: begin
               ResultSrc  = 2'b00;
               RegW       = 1'b1;
               state_next = FETCH;
            end
            BRANCH: begin
               // Flags come from rs1-rs2; target was computed in DECODE
               ALUControl = ALU_SUB;
               state_next = FETCH;
               case (Funct)
                  3'b000:         branch_taken = flag_z;
                  3'b001:         branch_taken = !flag_z;
                  3'b100:         branch_taken = flag_lt;
                  3'b101:         branch_taken = !flag_lt;
                  3'b010, 3'b011: state_next   = TRAP;
                  default:        branch_taken = 1'b0;
               endcase
               if (branch_taken) begin
                  ResultSrc = 2'b00;
                  PCNextSrc = 1'b1;
                  NextPC    = 1'b1;
               end
            end
            JAL: begin
               // PC <- target held in ALUOut while ALU forms the link value
               ResultSrc  = 2'b00;
               PCNextSrc  = 1'b1;
               NextPC     = 1'b1;
               AluSrcA    = 2'b10;
               AluSrcB    = 2'b10;
               state_next = ALUWB;
            end
            JALR: begin
               AluSrcB    = 2'b01;
               ResultSrc  = 2'b10;
               PCNextSrc  = 1'b1;
               NextPC     = 1'b1;
               state_next = JALR_LINK;
            end
            JALR_LINK: begin
               AluSrcA    = 2'b10;
               AluSrcB    = 2'b10;
               state_next = ALUWB;
            end
            LUI: begin
               RegWSrc    = 1'b1;
               RegW       = 1'b1;
               state_next = FETCH;
            end
            TRAP: begin
               trap       = 1'b1;
               state_next = TRAP;
            end
            default: state_next = TRAP;
         endcase
`ifdef MEM_WAIT_EN
         // Stalled memory states count waits and give up after the timeout
         if (!mem_ready && (state_reg == FETCH || state_reg == MEMREAD ||
                            state_reg == MEMWRITE)) begin
            if (wait_timeout) state_next    = TRAP;
            else              wait_cnt_next = wait_cnt_reg + 4'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm. Outputs are packed into one word and
// compared per cycle with hand-derived per-state output words.
// Word layout: {ALUControl[2:0], AdrSrc, IRWrite, NextPC, MemW, RegW,
//               PCNextSrc, ShiftSrc, RegWSrc, ResultSrc[1:0], AluSrcA[1:0],
//               AluSrcB[1:0], MaskEn[1:0], mem_read_state, trap}
module tb_main_control_fsm;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   localparam logic [20:0] E_ZERO       = 21'd0;
   localparam logic [20:0] E_TRAP       = 21'd1;
   localparam logic [20:0] E_FETCH      = {3'b000, 8'b0110_0100, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
   localparam logic [20:0] E_FETCH_WAIT = {3'b000, 8'b0000_0100, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
   localparam logic [20:0] E_DECODE     = {3'b000, 8'b0000_0000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
   localparam logic [20:0] E_SUB        = {3'b001, 8'b0000_0000, 10'b0};
   localparam logic [20:0] E_OR         = {3'b011, 8'b0000_0000, 10'b0};
   localparam logic [20:0] E_ADDI       = {3'b000, 8'b0000_0000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
   localparam logic [20:0] E_SLLI       = {3'b110, 8'b0000_0010, 10'b0};
   localparam logic [20:0] E_ALUWB      = {3'b000, 8'b0000_1000, 10'b0};
   localparam logic [20:0] E_MEMADR     = {3'b000, 8'b0000_0000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
   localparam logic [20:0] E_MEMREAD_W  = {3'b000, 8'b1000_0000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
   localparam logic [20:0] E_MEMWB      = {3'b000, 8'b0000_1000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [20:0] E_MEMWRITE   = {3'b000, 8'b1001_0000, 10'b0};
   localparam logic [20:0] E_BR_TAKEN   = {3'b001, 8'b0010_0100, 10'b0};
   localparam logic [20:0] E_BR_NT      = {3'b001, 8'b0000_0000, 10'b0};
   localparam logic [20:0] E_JAL        = {3'b000, 8'b0010_0100, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
   localparam logic [20:0] E_JALR       = {3'b000, 8'b0010_0100, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
   localparam logic [20:0] E_JALR_LINK  = {3'b000, 8'b0000_0000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
   localparam logic [20:0] E_LUI        = {3'b000, 8'b0000_1001, 10'b0};

   logic       clk;
   logic       rst;
   logic [6:0] OPCode;
   logic [2:0] Funct;
   logic       bit30;
   logic [3:0] ALUFlag;
   logic       mem_ready;
   logic [2:0] ALUControl;
   logic       AdrSrc, IRWrite, NextPC, MemW, RegW, PCNextSrc, ShiftSrc, RegWSrc;
   logic [1:0] ResultSrc, AluSrcA, AluSrcB, MaskEn;
   logic       mem_read_state;
   logic       trap;
   logic [20:0] obs;

   int tests_run;
   int tests_failed;

   main_control_fsm dut (
      .clk            (clk),
      .rst            (rst),
      .OPCode         (OPCode),
      .Funct          (Funct),
      .bit30          (bit30),
      .ALUFlag        (ALUFlag),
      .mem_ready      (mem_ready),
      .ALUControl     (ALUControl),
      .AdrSrc         (AdrSrc),
      .IRWrite        (IRWrite),
      .NextPC         (NextPC),
      .MemW           (MemW),
      .RegW           (RegW),
      .PCNextSrc      (PCNextSrc),
      .ShiftSrc       (ShiftSrc),
      .RegWSrc        (RegWSrc),
      .ResultSrc      (ResultSrc),
      .AluSrcA        (AluSrcA),
      .AluSrcB        (AluSrcB),
      .MaskEn         (MaskEn),
      .mem_read_state (mem_read_state),
      .trap           (trap)
   );

   assign obs = {ALUControl, AdrSrc, IRWrite, NextPC, MemW, RegW, PCNextSrc,
                 ShiftSrc, RegWSrc, ResultSrc, AluSrcA, AluSrcB, MaskEn,
                 mem_read_state, trap};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; sample point is 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic b30, input logic [3:0] flags);
      OPCode  = op;
      Funct   = f3;
      bit30   = b30;
      ALUFlag = flags;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      mem_ready = 1'b1;
      set_instr(OP_R, 3'b000, 1'b0, 4'b0000);
      step();
      step();
      tests_run++;
      if (obs !== E_ZERO) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, expected %h", obs, E_ZERO);
      end
      set_instr(OP_BAD, 3'b111, 1'b1, 4'b1111);
      step();
      tests_run++;
      if (obs !== E_ZERO) begin
         tests_failed++;
         $display("FAIL reset_outputs_any_input: got %h, expected %h", obs, E_ZERO);
      end
      set_instr(OP_R, 3'b000, 1'b0, 4'b0000);
      rst = 1'b0;
      #1;
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL first_fetch: got %h, expected %h", obs, E_FETCH);
      end
      $display("[TB] reset: outputs low during rst, FETCH right after release");
   endtask

   task automatic test_alu();
      logic [6:0]  ops   [4] = '{OP_R, OP_R, OP_I, OP_R};
      logic [2:0]  f3s   [4] = '{3'b000, 3'b000, 3'b001, 3'b110};
      logic        b30s  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [20:0] execs [4] = '{E_ZERO, E_SUB, E_SLLI, E_OR};
      logic [20:0] seq   [5];
      int          regw_cnt;
      for (int t = 0; t < 4; t++) begin
         set_instr(ops[t], f3s[t], b30s[t], 4'b0000);
         seq = '{E_FETCH, E_DECODE, execs[t], E_ALUWB, E_FETCH};
         regw_cnt = 0;
         for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (obs !== seq[i]) begin
               tests_failed++;
               $display("FAIL alu%0d_cycle%0d: got %h, expected %h", t, i, obs, seq[i]);
            end
            if (i < 4) begin
               regw_cnt += int'(RegW);
               step();
            end
         end
         tests_run++;
         if (regw_cnt !== 1) begin
            tests_failed++;
            $display("FAIL alu%0d_regw_pulses: got %0d, expected 1", t, regw_cnt);
         end
         $display("[TB] alu op=%b f3=%b b30=%b: 4-cycle sequence checked", ops[t], f3s[t], b30s[t]);
      end
   endtask

   task automatic test_addi_auipc();
      logic [20:0] seq_i [5] = '{E_FETCH, E_DECODE, E_ADDI, E_ALUWB, E_FETCH};
      logic [20:0] seq_a [4] = '{E_FETCH, E_DECODE, E_ALUWB, E_FETCH};
      set_instr(OP_I, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (obs !== seq_i[i]) begin
            tests_failed++;
            $display("FAIL addi_cycle%0d: got %h, expected %h", i, obs, seq_i[i]);
         end
         if (i < 4) step();
      end
      set_instr(OP_AUIPC, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs !== seq_a[i]) begin
            tests_failed++;
            $display("FAIL auipc_cycle%0d: got %h, expected %h", i, obs, seq_a[i]);
         end
         if (i < 3) step();
      end
      $display("[TB] addi and auipc: sequences checked");
   endtask

   task automatic test_lw();
      logic [20:0] seq [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD_W, E_MEMWB, E_FETCH};
      set_instr(OP_LOAD, 3'b010, 1'b0, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (obs !== seq[i]) begin
            tests_failed++;
            $display("FAIL lw_cycle%0d: got %h, expected %h", i, obs, seq[i]);
         end
         if (i < 5) step();
      end
      $display("[TB] lw: 5-state load sequence checked");
   endtask

   task automatic test_branch();
      logic [2:0]  f3s   [6] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b101};
      logic [3:0]  flags [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1001};
      logic        taken [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [20:0] seq   [4];
      for (int t = 0; t < 6; t++) begin
         set_instr(OP_BRANCH, f3s[t], 1'b0, flags[t]);
         seq = '{E_FETCH, E_DECODE, (taken[t] ? E_BR_TAKEN : E_BR_NT), E_FETCH};
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs !== seq[i]) begin
               tests_failed++;
               $display("FAIL branch%0d_cycle%0d: got %h, expected %h", t, i, obs, seq[i]);
            end
            if (i < 3) step();
         end
         $display("[TB] branch f3=%b flags=%b taken=%b: checked", f3s[t], flags[t], taken[t]);
      end
   endtask

   task automatic test_jumps();
      logic [20:0] seq_j [5] = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB, E_FETCH};
      logic [20:0] seq_r [6] = '{E_FETCH, E_DECODE, E_JALR, E_JALR_LINK, E_ALUWB, E_FETCH};
      logic [20:0] seq_l [4] = '{E_FETCH, E_DECODE, E_LUI, E_FETCH};
      set_instr(OP_JAL, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (obs !== seq_j[i]) begin
            tests_failed++;
            $display("FAIL jal_cycle%0d: got %h, expected %h", i, obs, seq_j[i]);
         end
         if (i < 4) step();
      end
      set_instr(OP_JALR, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (obs !== seq_r[i]) begin
            tests_failed++;
            $display("FAIL jalr_cycle%0d: got %h, expected %h", i, obs, seq_r[i]);
         end
         if (i < 5) step();
      end
      set_instr(OP_LUI, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs !== seq_l[i]) begin
            tests_failed++;
            $display("FAIL lui_cycle%0d: got %h, expected %h", i, obs, seq_l[i]);
         end
         if (i < 3) step();
      end
      $display("[TB] jal, jalr, lui: sequences checked");
   endtask

   task automatic test_illegal();
      logic [20:0] seq [3] = '{E_FETCH, E_DECODE, E_TRAP};
      set_instr(OP_BAD, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (obs !== seq[i]) begin
            tests_failed++;
            $display("FAIL illegal_cycle%0d: got %h, expected %h", i, obs, seq[i]);
         end
         if (i < 2) step();
      end
      // A legal opcode must not pull the FSM out of TRAP
      set_instr(OP_R, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (obs !== E_TRAP) begin
            tests_failed++;
            $display("FAIL trap_hold%0d: got %h, expected %h", i, obs, E_TRAP);
         end
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (obs !== E_ZERO) begin
         tests_failed++;
         $display("FAIL trap_reset: got %h, expected %h", obs, E_ZERO);
      end
      step();
      rst = 1'b0;
      #1;
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL trap_resume: got %h, expected %h", obs, E_FETCH);
      end
      $display("[TB] opcode 1111111: trap held until reset, FETCH resumed");
   endtask

   task automatic test_sra_trap();
      logic [20:0] seq [4] = '{E_FETCH, E_DECODE, E_ZERO, E_TRAP};
      set_instr(OP_R, 3'b101, 1'b1, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs !== seq[i]) begin
            tests_failed++;
            $display("FAIL sra_cycle%0d: got %h, expected %h", i, obs, seq[i]);
         end
         if (i < 3) step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL sra_resume: got %h, expected %h", obs, E_FETCH);
      end
      $display("[TB] sra: unsupported shift trapped");
   endtask

   task automatic test_reset_mid();
      logic [20:0] seq [4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE};
      set_instr(OP_STORE, 3'b010, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs !== seq[i]) begin
            tests_failed++;
            $display("FAIL sw_cycle%0d: got %h, expected %h", i, obs, seq[i]);
         end
         if (i < 3) step();
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (MemW !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_memw: got %b, expected 0", MemW);
      end
      tests_run++;
      if (obs !== E_ZERO) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got %h, expected %h", obs, E_ZERO);
      end
      step();
      tests_run++;
      if (obs !== E_ZERO) begin
         tests_failed++;
         $display("FAIL midreset_held: got %h, expected %h", obs, E_ZERO);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL midreset_fetch: got %h, expected %h", obs, E_FETCH);
      end
      $display("[TB] sw with reset in MEMWRITE: aborted, FETCH after release");
   endtask

`ifdef MEM_WAIT_EN
   task automatic test_mem_wait();
      int irw_cnt;
      irw_cnt = 0;
      set_instr(OP_R, 3'b000, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         tests_run++;
         if (obs !== ((i == 3) ? E_FETCH : E_FETCH_WAIT)) begin
            tests_failed++;
            $display("FAIL wait_fetch%0d: got %h, expected %h", i, obs,
                     ((i == 3) ? E_FETCH : E_FETCH_WAIT));
         end
         irw_cnt += int'(IRWrite);
         step();
      end
      tests_run++;
      if (irw_cnt !== 1) begin
         tests_failed++;
         $display("FAIL wait_irwrite_pulses: got %0d, expected 1", irw_cnt);
      end
      tests_run++;
      if (obs !== E_DECODE) begin
         tests_failed++;
         $display("FAIL wait_decode: got %h, expected %h", obs, E_DECODE);
      end
      step();
      step();
      step();
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL wait_back_fetch: got %h, expected %h", obs, E_FETCH);
      end
      $display("[TB] fetch with 3 wait cycles: single IRWrite checked");
      // Hold mem_ready low: 15 wait cycles, then TRAP
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         tests_run++;
         if (obs !== E_FETCH_WAIT) begin
            tests_failed++;
            $display("FAIL timeout_wait%0d: got %h, expected %h", i, obs, E_FETCH_WAIT);
         end
         step();
      end
      tests_run++;
      if (obs !== E_TRAP) begin
         tests_failed++;
         $display("FAIL timeout_trap: got %h, expected %h", obs, E_TRAP);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      $display("[TB] mem_ready stuck low: trap after 15 wait cycles checked");
   endtask
`else
   task automatic test_no_wait();
      logic [20:0] seq [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD_W, E_MEMWB, E_FETCH};
      mem_ready = 1'b0;
      set_instr(OP_LOAD, 3'b010, 1'b0, 4'b0000);
      #1;
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (obs !== seq[i]) begin
            tests_failed++;
            $display("FAIL nowait_cycle%0d: got %h, expected %h", i, obs, seq[i]);
         end
         if (i < 5) step();
      end
      mem_ready = 1'b1;
      $display("[TB] lw with mem_ready low: handshake ignored, one cycle per state");
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_alu();
      test_addi_auipc();
      test_lw();
      test_branch();
      test_jumps();
      test_illegal();
      test_sra_trap();
      test_reset_mid();
`ifdef MEM_WAIT_EN
      test_mem_wait();
`else
      test_no_wait();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
